// File: rtl/wb_arbiter.sv
// Writeback arbiter: three producer FIFOs (ALU, MEM, MDU) drained round-robin onto two regfile write ports.
// Optional same-cycle bypass of empty FIFOs is enabled by defining WB_BYPASS_EN.
module wb_arbiter #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned XLEN  = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic            mdu_valid,
   output logic            mdu_ready,
   input  logic [4:0]      mdu_rd,
   input  logic [XLEN-1:0] mdu_data,
   output logic [4:0]      wreg0,
   output logic [XLEN-1:0] wdata0,
   output logic            wen0,
   output logic [4:0]      wreg1,
   output logic [XLEN-1:0] wdata1,
   output logic            wen1,
   output logic            idle
);
   localparam int unsigned NSRC = 3;
   localparam int unsigned RW   = 5;
   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = PW + 1;

   logic [NSRC-1:0]           in_valid;
   logic [NSRC-1:0][RW-1:0]   in_rd;
   logic [NSRC-1:0][XLEN-1:0] in_data;

   logic [RW-1:0]             fifo_rd   [NSRC][DEPTH];
   logic [XLEN-1:0]           fifo_data [NSRC][DEPTH];
   logic [NSRC-1:0][PW-1:0]   rptr;
   logic [NSRC-1:0][PW-1:0]   wptr;
   logic [NSRC-1:0][CW-1:0]   count;
   logic [NSRC-1:0][CW-1:0]   count_nxt;
   logic [NSRC-1:0]           ready_q;
   logic [1:0]                rr;
   logic [1:0]                rr_nxt;

   logic [NSRC-1:0]           elig;
   logic [NSRC-1:0]           byp;
   logic [NSRC-1:0]           push;
   logic [NSRC-1:0]           pop;
   logic [NSRC-1:0]           granted;
   logic [NSRC-1:0][RW-1:0]   head_rd;
   logic [NSRC-1:0][XLEN-1:0] head_data;
   logic                      ga;
   logic                      gb;
   logic                      found_b;
   logic [1:0]                ia;
   logic [1:0]                ib;
   logic [2:0]                scan_sum;
   logic [1:0]                scan_idx;
   logic                      all_empty_nxt;

   assign in_valid   = {mdu_valid, mem_valid, alu_valid};
   assign in_rd      = {mdu_rd, mem_rd, alu_rd};
   assign in_data    = {mdu_data, mem_data, alu_data};
   assign alu_ready  = ready_q[0];
   assign mem_ready  = ready_q[1];
   assign mdu_ready  = ready_q[2];

   // Per-source head and grant eligibility
   always_comb begin
      byp       = '0;
      elig      = '0;
      head_rd   = '0;
      head_data = '0;
      for (int i = 0; i < NSRC; i++) begin
         head_rd[i]   = fifo_rd[i][rptr[i]];
         head_data[i] = fifo_data[i][rptr[i]];
         elig[i]      = (count[i] != '0);
`ifdef WB_BYPASS_EN
         if ((count[i] == '0) && in_valid[i] && (in_rd[i] != '0)) begin
            byp[i]       = 1'b1;
            elig[i]      = 1'b1;
            head_rd[i]   = in_rd[i];
            head_data[i] = in_data[i];
         end
`endif
      end
   end

   // Round-robin scan from rr: first eligible head is A, next is B unless it targets the same rd
   always_comb begin
      ga       = 1'b0;
      found_b  = 1'b0;
      ia       = 2'd0;
      ib       = 2'd0;
      scan_sum = 3'd0;
      scan_idx = 2'd0;
      rr_nxt   = rr;
      for (int k = 0; k < NSRC; k++) begin
         scan_sum = 3'(rr) + 3'(k);
         if (scan_sum >= 3'(NSRC)) scan_sum = scan_sum - 3'(NSRC);
         scan_idx = scan_sum[1:0];
         if (elig[scan_idx]) begin
            if (!ga) begin
               ga = 1'b1;
               ia = scan_idx;
            end else if (!found_b) begin
               found_b = 1'b1;
               ib      = scan_idx;
            end
         end
      end
      gb = found_b && (head_rd[ib] != head_rd[ia]);
      if (gb)      rr_nxt = (ib == 2'd2) ? 2'd0 : ib + 2'd1;
      else if (ga) rr_nxt = (ia == 2'd2) ? 2'd0 : ia + 2'd1;
   end

   // FIFO push/pop and next occupancy
   always_comb begin
      granted       = '0;
      pop           = '0;
      push          = '0;
      count_nxt     = count;
      all_empty_nxt = 1'b1;
      for (int i = 0; i < NSRC; i++) begin
         granted[i]   = (ga && (ia == 2'(i))) || (gb && (ib == 2'(i)));
         pop[i]       = granted[i] && (count[i] != '0);
         push[i]      = in_valid[i] && ready_q[i] && (in_rd[i] != '0) && !(byp[i] && granted[i]);
         count_nxt[i] = count[i] + CW'(push[i]) - CW'(pop[i]);
         if (count_nxt[i] != '0) all_empty_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rptr    <= '0;
         wptr    <= '0;
         count   <= '0;
         ready_q <= '1;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (push[i]) wptr[i] <= wptr[i] + PW'(1);
            if (pop[i])  rptr[i] <= rptr[i] + PW'(1);
            count[i]   <= count_nxt[i];
            ready_q[i] <= (count_nxt[i] != CW'(DEPTH));
         end
      end
   end

   // Entry storage needs no reset; occupancy is tracked by count
   always_ff @(posedge clk) begin
      for (int i = 0; i < NSRC; i++) begin
         if (push[i]) begin
            fifo_rd[i][wptr[i]]   <= in_rd[i];
            fifo_data[i][wptr[i]] <= in_data[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wen0   <= 1'b0;
         wen1   <= 1'b0;
         wreg0  <= '0;
         wreg1  <= '0;
         wdata0 <= '0;
         wdata1 <= '0;
         rr     <= 2'd0;
         idle   <= 1'b1;
      end else begin
         wen0 <= ga;
         wen1 <= gb;
         if (ga) begin
            wreg0  <= head_rd[ia];
            wdata0 <= head_data[ia];
         end
         if (gb) begin
            wreg1  <= head_rd[ib];
            wdata1 <= head_data[ib];
         end
         rr   <= rr_nxt;
         idle <= all_empty_nxt && !ga && !gb;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (default build): directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_wb_arbiter;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned XLEN  = 32;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            alu_valid, mem_valid, mdu_valid;
   logic            alu_ready, mem_ready, mdu_ready;
   logic [4:0]      alu_rd, mem_rd, mdu_rd;
   logic [XLEN-1:0] alu_data, mem_data, mdu_data;
   logic [4:0]      wreg0, wreg1;
   logic [XLEN-1:0] wdata0, wdata1;
   logic            wen0, wen1, idle;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: one queue of {rd,data} per source
   logic [36:0]     mq [3][$];
   int              m_rr;
   logic            mv [3];
   logic [4:0]      mr [3];
   logic [XLEN-1:0] md [3];
   logic            e_wen0, e_wen1, e_idle;
   logic [4:0]      e_reg0, e_reg1;
   logic [XLEN-1:0] e_dat0, e_dat1;
   logic [2:0]      e_rdy;

   wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
      .wreg0(wreg0), .wdata0(wdata0), .wen0(wen0),
      .wreg1(wreg1), .wdata1(wdata1), .wen1(wen1),
      .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic set_src(input int s, input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
      case (s)
         0: begin alu_valid = v; alu_rd = rd; alu_data = d; end
         1: begin mem_valid = v; mem_rd = rd; mem_data = d; end
         default: begin mdu_valid = v; mdu_rd = rd; mdu_data = d; end
      endcase
   endtask

   task automatic clear_inputs();
      for (int s = 0; s < 3; s++) set_src(s, 1'b0, 5'd0, '0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({wen0, wen1, idle} !== 3'b001) begin
         n_fail++; $display("FAIL reset_ctrl: wen0/wen1/idle got %b want 001", {wen0, wen1, idle});
      end
      n_cmp++;
      if ({wreg0, wreg1, wdata0, wdata1} !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h want zeros", wreg0, wreg1, wdata0, wdata1);
      end
      n_cmp++;
      if ({mdu_ready, mem_ready, alu_ready} !== 3'b111) begin
         n_fail++; $display("FAIL reset_ready: got %b want 111", {mdu_ready, mem_ready, alu_ready});
      end
   endtask

   task automatic test_single_write();
      do_reset();
      set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      clear_inputs();
      n_cmp++;
      if ({wen0, wen1, idle} !== 3'b000) begin
         n_fail++; $display("FAIL single_accept: wen0/wen1/idle got %b want 000", {wen0, wen1, idle});
      end
      tick();
      n_cmp++;
      if ({wen0, wreg0, wdata0, wen1} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
         n_fail++; $display("FAIL single_write: got wen0=%b rd=%0d data=%h wen1=%b want 1/5/deadbeef/0",
                            wen0, wreg0, wdata0, wen1);
      end
      tick();
      n_cmp++;
      if ({idle, wen0, wreg0, wdata0} !== {1'b1, 1'b0, 5'd5, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL single_idle: got idle=%b wen0=%b rd=%0d data=%h want 1/0/5/deadbeef",
                            idle, wen0, wreg0, wdata0);
      end
   endtask

   task automatic test_dual_write();
      do_reset();
      set_src(0, 1'b1, 5'd3, 32'h11);
      set_src(1, 1'b1, 5'd4, 32'h22);
      tick();
      clear_inputs();
      tick();
      n_cmp++;
      if ({wen0, wreg0, wdata0, wen1, wreg1, wdata1} !== {1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22}) begin
         n_fail++; $display("FAIL dual_write: got %b/%0d/%h %b/%0d/%h want 1/3/11 1/4/22",
                            wen0, wreg0, wdata0, wen1, wreg1, wdata1);
      end
      // rr now at MDU: MDU must win port 0 over ALU
      set_src(0, 1'b1, 5'd8, 32'h88);
      set_src(2, 1'b1, 5'd9, 32'h99);
      tick();
      clear_inputs();
      tick();
      n_cmp++;
      if ({wen0, wreg0, wdata0, wen1, wreg1, wdata1} !== {1'b1, 5'd9, 32'h99, 1'b1, 5'd8, 32'h88}) begin
         n_fail++; $display("FAIL dual_rr_mdu: got %b/%0d/%h %b/%0d/%h want 1/9/99 1/8/88",
                            wen0, wreg0, wdata0, wen1, wreg1, wdata1);
      end
   endtask

   task automatic test_round_robin();
      int seq [3];
      int popcnt [3];
      int pa [3];
      int pb [3];
      logic [2:0] acc;
      int ea, eb;
      pa = '{0, 2, 1};
      pb = '{1, 0, 2};
      for (int s = 0; s < 3; s++) begin seq[s] = 0; popcnt[s] = 0; end
      do_reset();
      for (int c = 0; c < 10; c++) begin
         for (int s = 0; s < 3; s++)
            set_src(s, 1'b1, 5'(s * 10 + (seq[s] % 10) + 1), {4'(s), 28'(seq[s])});
         acc = {mdu_ready, mem_ready, alu_ready};
         tick();
         for (int s = 0; s < 3; s++) if (acc[s]) seq[s]++;
         if (c >= 1) begin
            ea = pa[(c - 1) % 3];
            eb = pb[(c - 1) % 3];
            n_cmp++;
            if ({wen0, wen1, wdata0, wdata1} !== {2'b11, 4'(ea), 28'(popcnt[ea]), 4'(eb), 28'(popcnt[eb])}) begin
               n_fail++; $display("FAIL rr_cycle%0d: got wen=%b%b d0=%h d1=%h want src %0d#%0d and %0d#%0d",
                                  c, wen0, wen1, wdata0, wdata1, ea, popcnt[ea], eb, popcnt[eb]);
            end
            popcnt[ea]++;
            popcnt[eb]++;
         end
      end
      clear_inputs();
   endtask

   task automatic test_same_rd();
      do_reset();
      set_src(1, 1'b1, 5'd7, 32'h1);
      set_src(2, 1'b1, 5'd7, 32'h2);
      tick();
      clear_inputs();
      tick();
      n_cmp++;
      if ({wen0, wreg0, wdata0, wen1} !== {1'b1, 5'd7, 32'h1, 1'b0}) begin
         n_fail++; $display("FAIL same_rd_c1: got %b/%0d/%h wen1=%b want 1/7/1 wen1=0", wen0, wreg0, wdata0, wen1);
      end
      tick();
      n_cmp++;
      if ({wen0, wreg0, wdata0, wen1} !== {1'b1, 5'd7, 32'h2, 1'b0}) begin
         n_fail++; $display("FAIL same_rd_c2: got %b/%0d/%h wen1=%b want 1/7/2 wen1=0", wen0, wreg0, wdata0, wen1);
      end
      tick();
      n_cmp++;
      if ({wen0, wen1, idle} !== 3'b001) begin
         n_fail++; $display("FAIL same_rd_done: wen0/wen1/idle got %b want 001", {wen0, wen1, idle});
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      // One ALU write moves rr to MEM so MEM/MDU outrank ALU next
      set_src(0, 1'b1, 5'd1, 32'h100);
      tick();
      clear_inputs();
      tick();
      tick();
      set_src(0, 1'b1, 5'd10, 32'hA1);
      set_src(1, 1'b1, 5'd11, 32'hB1);
      set_src(2, 1'b1, 5'd12, 32'hC1);
      tick();
      clear_inputs();
      set_src(0, 1'b1, 5'd13, 32'hA2);
      tick();
      n_cmp++;
      if ({wen0, wreg0, wen1, wreg1, alu_ready} !== {1'b1, 5'd11, 1'b1, 5'd12, 1'b0}) begin
         n_fail++; $display("FAIL bp_full: got wen0=%b rd0=%0d wen1=%b rd1=%0d alu_ready=%b want 1/11/1/12/0",
                            wen0, wreg0, wen1, wreg1, alu_ready);
      end
      set_src(0, 1'b1, 5'd14, 32'hA3);
      tick();
      n_cmp++;
      if ({wen0, wreg0, wdata0, wen1, alu_ready} !== {1'b1, 5'd10, 32'hA1, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL bp_pop1: got %b/%0d/%h wen1=%b ready=%b want 1/10/a1/0/1",
                            wen0, wreg0, wdata0, wen1, alu_ready);
      end
      tick();
      clear_inputs();
      n_cmp++;
      if ({wen0, wreg0, wdata0} !== {1'b1, 5'd13, 32'hA2}) begin
         n_fail++; $display("FAIL bp_pop2: got %b/%0d/%h want 1/13/a2", wen0, wreg0, wdata0);
      end
      tick();
      n_cmp++;
      if ({wen0, wreg0, wdata0} !== {1'b1, 5'd14, 32'hA3}) begin
         n_fail++; $display("FAIL bp_held: got %b/%0d/%h want 1/14/a3", wen0, wreg0, wdata0);
      end
      tick();
      n_cmp++;
      if ({wen0, wen1, idle} !== 3'b001) begin
         n_fail++; $display("FAIL bp_drain: wen0/wen1/idle got %b want 001", {wen0, wen1, idle});
      end
      set_src(0, 1'b1, 5'd0, 32'h55);
      tick();
      clear_inputs();
      n_cmp++;
      if ({alu_ready, idle, wen0} !== 3'b110) begin
         n_fail++; $display("FAIL rd0_accept: ready/idle/wen0 got %b want 110", {alu_ready, idle, wen0});
      end
      tick();
      n_cmp++;
      if ({wen0, wen1, idle} !== 3'b001) begin
         n_fail++; $display("FAIL rd0_nowrite: wen0/wen1/idle got %b want 001", {wen0, wen1, idle});
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      for (int s = 0; s < 3; s++) set_src(s, 1'b1, 5'(s + 1), 32'(s + 1));
      tick();
      for (int s = 0; s < 3; s++) set_src(s, 1'b1, 5'(s + 4), 32'(s + 4));
      tick();
      clear_inputs();
      n_cmp++;
      if ({wen0, wreg0, idle} !== {1'b1, 5'd1, 1'b0}) begin
         n_fail++; $display("FAIL midop_busy: got wen0=%b rd0=%0d idle=%b want 1/1/0", wen0, wreg0, idle);
      end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({wen0, wen1} !== 2'b00) begin
         n_fail++; $display("FAIL midop_async: wen0/wen1 got %b want 00", {wen0, wen1});
      end
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      n_cmp++;
      if ({mdu_ready, mem_ready, alu_ready, idle} !== 4'b1111) begin
         n_fail++; $display("FAIL midop_release: ready/idle got %b want 1111", {mdu_ready, mem_ready, alu_ready, idle});
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++;
         if ({wen0, wen1, idle} !== 3'b001) begin
            n_fail++; $display("FAIL midop_stale%0d: wen0/wen1/idle got %b want 001", c, {wen0, wen1, idle});
         end
      end
   endtask

   // One clock edge of the reference model from the spec's rules
   task automatic model_step();
      logic [2:0]  rdy_now;
      logic [36:0] ent_a, ent_b;
      int a, b, s;
      for (int i = 0; i < 3; i++) rdy_now[i] = (mq[i].size() != DEPTH);
      a = -1;
      b = -1;
      for (int k = 0; k < 3; k++) begin
         s = (m_rr + k) % 3;
         if (mq[s].size() != 0) begin
            if (a < 0) a = s;
            else if (b < 0) b = s;
         end
      end
      ent_a = '0;
      ent_b = '0;
      if (a >= 0) ent_a = mq[a][0];
      if (b >= 0) ent_b = mq[b][0];
      if (b >= 0 && ent_a[36:32] == ent_b[36:32]) b = -1;
      e_wen0 = (a >= 0);
      e_wen1 = (b >= 0);
      if (a >= 0) begin
         e_reg0 = ent_a[36:32]; e_dat0 = ent_a[31:0]; void'(mq[a].pop_front()); m_rr = (a + 1) % 3;
      end
      if (b >= 0) begin
         e_reg1 = ent_b[36:32]; e_dat1 = ent_b[31:0]; void'(mq[b].pop_front()); m_rr = (b + 1) % 3;
      end
      for (int i = 0; i < 3; i++)
         if (mv[i] && rdy_now[i] && mr[i] != 5'd0) mq[i].push_back({mr[i], md[i]});
      e_idle = !e_wen0 && !e_wen1 && mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0;
      for (int i = 0; i < 3; i++) e_rdy[i] = (mq[i].size() != DEPTH);
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3; i++) mq[i].delete();
      m_rr = 0;
      e_reg0 = '0; e_reg1 = '0; e_dat0 = '0; e_dat1 = '0;
      for (int c = 0; c < 600; c++) begin
         for (int s = 0; s < 3; s++) begin
            mv[s] = ($urandom_range(0, 99) < 55);
            mr[s] = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            md[s] = $urandom();
            set_src(s, mv[s], mr[s], md[s]);
         end
         model_step();
         tick();
         n_cmp++;
         if ({wen0, wreg0, wdata0, wen1, wreg1, wdata1} !== {e_wen0, e_reg0, e_dat0, e_wen1, e_reg1, e_dat1}) begin
            n_fail++; $display("FAIL rand_ports c%0d: got %b/%0d/%h %b/%0d/%h want %b/%0d/%h %b/%0d/%h", c,
                               wen0, wreg0, wdata0, wen1, wreg1, wdata1, e_wen0, e_reg0, e_dat0, e_wen1, e_reg1, e_dat1);
         end
         n_cmp++;
         if ({mdu_ready, mem_ready, alu_ready, idle} !== {e_rdy, e_idle}) begin
            n_fail++; $display("FAIL rand_status c%0d: ready/idle got %b want %b", c,
                               {mdu_ready, mem_ready, alu_ready, idle}, {e_rdy, e_idle});
         end
      end
      clear_inputs();
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      test_reset();
      test_single_write();
      test_dual_write();
      test_round_robin();
      test_same_rd();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback collector between the execution units (ALU, load/store, mul/div) and the register file's two write ports.
- Each producer hands over (rd, data) through a valid/ready handshake into a per-source FIFO.
- Each cycle the block picks up to two FIFO heads round-robin and drives registered wreg0/wdata0/wen0 and wreg1/wdata1/wen1, which complete the scoreboard reservation in the register file.

Parameters:
- DEPTH, 2, per-source FIFO entries; power of two, >= 2.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU FIFO can accept.
- alu_rd  in  5  destination register.
- alu_data  in  XLEN  result.
- mem_valid, mem_ready, mem_rd, mem_data  in/out/in/in  1/1/5/XLEN  same as alu_*, for the load unit.
- mdu_valid, mdu_ready, mdu_rd, mdu_data  in/out/in/in  1/1/5/XLEN  same as alu_*, for mul/div.
- wreg0  out  5  write port 0 register.
- wdata0  out  XLEN  write port 0 data.
- wen0  out  1  write port 0 enable.
- wreg1  out  5  write port 1 register.
- wdata1  out  XLEN  write port 1 data.
- wen1  out  1  write port 1 enable.
- idle  out  1  all FIFOs empty and wen0=wen1=0.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty; wen0=wen1=0; wreg0/1=0; wdata0/1=0; rr pointer=ALU; idle=1.
- Handshake:
  - x_ready = (count_x != DEPTH), from registered count only; no combinational path from valid to ready.
  - Transfer when x_valid & x_ready at a rising edge.
  - A full FIFO deasserts ready even in a cycle where its head is dequeued.
- rd==0 transfers are accepted (ready honoured) but not enqueued; they never reach a write port.
- Source order is ALU(0), MEM(1), MDU(2).
- Arbitration, combinational from registered FIFO state:
  - Scan the three sources starting at rr pointer, wrapping 2->0.
  - First non-empty head -> grant A; next non-empty head -> grant B.
  - If B.rd == A.rd, B is not granted this cycle.
- Output registers at the edge:
  - wen0 <= A granted, wreg0/wdata0 <= A.rd/A.data.
  - wen1 <= B granted, wreg1/wdata1 <= B.rd/B.data.
  - Granted heads are popped.
  - When wen is 0, wreg/wdata hold their previous value.
- rr pointer <= source after the last granted source; unchanged if nothing granted.
- Latency:
  - Data accepted at edge N into an empty FIFO with no competition appears on the write port from edge N+1.
  - It is visible in the regfile after edge N+2.
- Throughput: up to 2 writes/cycle total; at most 1 pop per source per cycle.
- FIFO wrap: read/write pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Simultaneous push and pop on one FIFO: count unchanged; data ordering preserved.
- Push into an empty FIFO is not eligible for grant until the following cycle (no bypass in the base build).
- Per-source ordering is strict FIFO. No ordering is guaranteed across sources; the issue stage allows one outstanding write per rd.
- Reset mid-operation: in-flight entries are discarded; wen0/wen1 drop immediately on reset_n low.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: a source whose FIFO is empty and whose x_valid is high is eligible in the same cycle, using its input rd/data directly.
  - If granted, the entry is not enqueued; write-port latency drops to 1 edge.
  - x_ready stays registered-count based.
  - rd==0 inputs are still never granted.
- Undefined: behaviour exactly as in Behaviour above.

Test Plan:
- Single write: alu_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> next cycle wen0=1, wreg0=5, wdata0=0xDEADBEEF, wen1=0; following cycle idle=1.
- Dual write: alu rd=3 data=0x11 and mem rd=4 data=0x22 in the same cycle, rr=ALU -> next cycle wen0/wreg0/wdata0 = 1/3/0x11 and wen1/wreg1/wdata1 = 1/4/0x22; rr -> MDU.
- Round-robin fairness: all three FIFOs kept non-empty -> grant pairs cycle (ALU,MEM), (MDU,ALU), (MEM,MDU), ...; no source starves more than 1 cycle.
- Same-rd conflict: mem rd=7 data=0x1 and mdu rd=7 data=0x2 together -> cycle 1 only wen0 with the first-scanned source, wen1=0; cycle 2 the other on wen0.
- Backpressure and rd==0: DEPTH=2, ALU held from grant by MEM/MDU traffic, 3 ALU pushes -> alu_ready=0 after 2 entries; 3rd held and accepted once 1 pops. alu rd=0 push -> accepted, no wen.
- Reset mid-op: FIFOs holding 4 entries, reset_n pulsed low mid-cycle -> wen0=wen1=0 immediately, all ready=1 and idle=1 after release, no stale writes.
